// File: rtl/score_pkg.sv
// Shared types and default sizes for the binary-to-BCD score path.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    localparam int SCORE_W_DEF = 16;
    localparam int DIGITS_DEF  = 5;

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble correction step: each BCD nibble >= 5 gets +3 before the shift.
module bcd_adjust
    import score_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic [4*DIGITS-1:0] din,
    output logic [4*DIGITS-1:0] dout
);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nib
            // Nibbles are adjusted independently; the sum never exceeds 4 bits.
            assign dout[4*gi +: 4] = (din[4*gi +: 4] >= 4'd5) ? din[4*gi +: 4] + 4'd3
                                                               : din[4*gi +: 4];
        end
    endgenerate

endmodule

// File: rtl/score_bcd.sv
// Iterative binary-to-BCD converter for the score display, plus a session high score
// that only a reset clears.
module score_bcd
    import score_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int DIGITS  = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                Reset_n,
    input  logic [SCORE_W-1:0]  score,
    output logic [4*DIGITS-1:0] digits,
    output logic [4*DIGITS-1:0] hi_digits,
    output logic                busy,
    output logic                update
);

    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(SCORE_W);

    bcd_state_t             state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    // {bcd, bin} kept as one register so the shift carries bin MSB into bcd LSB.
    logic [BW+SCORE_W-1:0]  sr_reg;
    logic [SCORE_W-1:0]     cap_reg;
    logic [SCORE_W-1:0]     last_score_reg;
    logic [SCORE_W-1:0]     hi_score_reg;
    logic [BW-1:0]          digits_reg;
    logic [BW-1:0]          hi_digits_reg;
    logic [BW-1:0]          adj_next;
    logic                   busy_reg;
    logic                   upd_pend_reg;
    logic                   update_reg;

    bcd_adjust #(
        .DIGITS (DIGITS)
    ) u_adjust (
        .din  (sr_reg[BW+SCORE_W-1:SCORE_W]),
        .dout (adj_next)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            sr_reg         <= '0;
            cap_reg        <= '0;
            last_score_reg <= '0;
            hi_score_reg   <= '0;
            digits_reg     <= '0;
            hi_digits_reg  <= '0;
            busy_reg       <= 1'b0;
            upd_pend_reg   <= 1'b0;
            update_reg     <= 1'b0;
        end else begin
            upd_pend_reg <= 1'b0;
            update_reg   <= upd_pend_reg;
            case (state_reg)
                IDLE: begin
                    if (score != last_score_reg) begin
                        cap_reg   <= score;
                        sr_reg    <= {{BW{1'b0}}, score};
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_reg  <= {adj_next, sr_reg[SCORE_W-1:0]} << 1;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(SCORE_W - 1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    digits_reg     <= sr_reg[BW+SCORE_W-1:SCORE_W];
                    last_score_reg <= cap_reg;
                    if (cap_reg > hi_score_reg) begin
                        hi_score_reg  <= cap_reg;
                        hi_digits_reg <= sr_reg[BW+SCORE_W-1:SCORE_W];
                    end
                    upd_pend_reg <= 1'b1;
                    busy_reg     <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign digits    = digits_reg;
    assign hi_digits = hi_digits_reg;
    assign busy      = busy_reg;
    assign update    = update_reg;

endmodule

// File: tb/tb_score_bcd.sv
// Randomized scoreboard bench for score_bcd: expectations come from a decimal model.
module tb_score_bcd;

    logic        clk;
    logic        Reset_n;
    logic [15:0] score;
    logic [19:0] digits;
    logic [19:0] hi_digits;
    logic        busy;
    logic        update;

    typedef struct {
        int dig;
        int hi;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   model_last = 0;
    int   model_hi = 0;

    score_bcd dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .score     (score),
        .digits    (digits),
        .hi_digits (hi_digits),
        .busy      (busy),
        .update    (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int to_bcd(input int v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < 5; i++) begin
            r = r | (((v / p) % 10) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every update pulse consumes exactly one scoreboard entry.
    always @(negedge clk) begin
        if (Reset_n && update) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_update: got update with empty scoreboard, digits=0x%0h (cycle %0d)",
                         digits, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("digits", int'(digits), e.dig);
                check("hi_digits", int'(hi_digits), e.hi);
                check("update_cycle", cyc, e.cyc);
            end
        end
    end

    // Model of one accepted score sample; capture edge is the one after the call.
    task automatic expect_conv(input int v, input int cap_cyc);
        exp_t e;
        model_last = v;
        if (v > model_hi) model_hi = v;
        e.dig = to_bcd(v);
        e.hi  = to_bcd(model_hi);
        e.cyc = cap_cyc + 18;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 120 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: %0d results pending, required 0", name, q.size());
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic set_score(input int v);
        bit conv;
        @(posedge clk);
        #1;
        score = 16'(v);
        conv  = (v != model_last);
        if (conv) expect_conv(v, cyc + 1);
        @(posedge clk);
        @(negedge clk);
        check("busy_after_capture", int'(busy), conv ? 1 : 0);
        drain("set_score");
    endtask

    task automatic do_reset();
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_digits", int'(digits), 0);
        check("rst_hi_digits", int'(hi_digits), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_update", int'(update), 0);
        q.delete();
        model_last = 0;
        model_hi   = 0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int v;
        int busy_seen;
        Reset_n = 1'b0;
        score   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_digits", int'(digits), 0);
        check("rst_busy", int'(busy), 0);
        Reset_n = 1'b1;

        // Idle with score 0: no conversion may start.
        busy_seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) busy_seen = 1;
        end
        check("idle_busy_seen", busy_seen, 0);
        check("idle_digits", int'(digits), 0);
        check("idle_hi_digits", int'(hi_digits), 0);

        set_score(1234);
        set_score(65535);
        set_score(0);
        check("gameover_hi_kept", int'(hi_digits), 'h65535);

        @(negedge clk);
        do_reset();
        #1 Reset_n = 1'b1;
        set_score(500);
        set_score(300);
        check("hi_kept_500", int'(hi_digits), 'h00500);

        // Score changes mid-SHIFT: first result is the captured value, then a back-to-back redo.
        @(posedge clk);
        #1;
        score = 16'd100;
        expect_conv(100, cyc + 1);
        expect_conv(150, cyc + 1 + 18);
        repeat (4) @(posedge clk);
        #1 score = 16'd150;
        drain("mid_change");

        // Reset during a conversion aborts it and loses the high score.
        @(posedge clk);
        #1 score = 16'd9999;
        repeat (6) @(posedge clk);
        do_reset();
        #1 Reset_n = 1'b1;
        expect_conv(9999, cyc + 1);
        drain("post_reset");
        check("post_reset_hi", int'(hi_digits), 'h09999);

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 5))
                0:       v = model_last;
                1:       v = 0;
                2:       v = 65535;
                default: v = int'($urandom_range(0, 65535));
            endcase
            set_score(v);
        end

        repeat (30) @(negedge clk);
        check("final_queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule
